// File: rtl/nanorv32_icode_ahb_slave_pkg.sv
// Shared constants, FSM encoding and the code-region range check for the instruction-side AHB slave.
// Pure declarations; no logic or latency of its own.
// No flow control lives here; it is imported by nanorv32_icode_ahb_slave.
package nanorv32_icode_ahb_slave_pkg;

    localparam logic       NANORV32_HRESP_OKAY  = 1'b0;
    localparam logic       NANORV32_HRESP_ERROR = 1'b1;
    localparam logic [2:0] NANORV32_HSIZE_WORD  = 3'b010;

    typedef enum logic [2:0] {
        NANORV32_ST_IDLE = 3'd0,
        NANORV32_ST_WAIT = 3'd1,
        NANORV32_ST_DATA = 3'd2,
        NANORV32_ST_ERR1 = 3'd3,
        NANORV32_ST_ERR2 = 3'd4
    } icode_state_e;

    // 33-bit offset so an address below the base wraps to a huge value and an
    // address near 32'hFFFF_FFFC cannot wrap back into the region.
    function automatic logic in_code_region(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned aw);
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, base};
        return offset < (33'd1 << (aw + 2));
    endfunction

endpackage

// File: rtl/nanorv32_icode_ahb_slave.sv
// Read-only AHB-lite slave feeding the instruction prefetch master from a synchronous code memory.
// Latency: WAIT_STATES+1 cycles accept-to-data; zero-wait back-to-back reads give one word per cycle.
// Backpressure: hreadyi=0 during wait cycles and ERR1; address phases presented while stalled are ignored.
// Ports: clk/rst_n; AHB address phase haddri/htransi/hsizei/hwritei; data phase hrdatai/hreadyi/hrespi;
//        code memory mem_cs/mem_addr out, mem_rdata in (valid the cycle after mem_cs).
module nanorv32_icode_ahb_slave
    import nanorv32_icode_ahb_slave_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned MEM_AW      = 14,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       haddri,
    input  logic              htransi,
    input  logic [2:0]        hsizei,
    input  logic              hwritei,
    output logic [31:0]       hrdatai,
    output logic              hreadyi,
    output logic              hrespi,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    icode_state_e      state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       hold_q, hold_d;       // last value driven on hrdatai
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

    logic legal;
    logic ready_c;

    assign legal = !hwritei
                && (hsizei == NANORV32_HSIZE_WORD)
                && (haddri[1:0] == 2'b00)
                && in_code_region(haddri, MEM_BASE, MEM_AW);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        ready_c    = 1'b1;
        hrespi     = NANORV32_HRESP_OKAY;
        hrdatai    = hold_q;
        mem_cs     = 1'b0;
        mem_addr   = mem_addr_q;

        unique case (state_q)
            NANORV32_ST_IDLE: begin
            end
            NANORV32_ST_WAIT: begin
                ready_c = 1'b0;
                // Memory data is only guaranteed in the first wait cycle.
                if (cnt_q == WS) begin
                    rdata_d = mem_rdata;
                end
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = NANORV32_ST_DATA;
                end
            end
            NANORV32_ST_DATA: begin
                hrdatai = (WAIT_STATES == 0) ? mem_rdata : rdata_q;
                state_d = NANORV32_ST_IDLE;
            end
            NANORV32_ST_ERR1: begin
                ready_c = 1'b0;
                hrespi  = NANORV32_HRESP_ERROR;
                state_d = NANORV32_ST_ERR2;
            end
            NANORV32_ST_ERR2: begin
                hrespi  = NANORV32_HRESP_ERROR;
                hrdatai = 32'h0;
                state_d = NANORV32_ST_IDLE;
            end
            default: begin
                state_d = NANORV32_ST_IDLE;
            end
        endcase

        // Address phase: overrides the return to IDLE from DATA/ERR2 so the
        // address and data phases overlap.
        if (ready_c && htransi) begin
            if (legal) begin
                mem_cs     = 1'b1;
                mem_addr   = haddri[MEM_AW+1:2];
                mem_addr_d = haddri[MEM_AW+1:2];
                if (WAIT_STATES == 0) begin
                    state_d = NANORV32_ST_DATA;
                end else begin
                    state_d = NANORV32_ST_WAIT;
                    cnt_d   = WS;
                end
            end else begin
                state_d = NANORV32_ST_ERR1;
            end
        end

        hreadyi = ready_c;
        hold_d  = hrdatai;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NANORV32_ST_IDLE;
            cnt_q      <= 3'd0;
            rdata_q    <= 32'h0;
            hold_q     <= 32'h0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            hold_q     <= hold_d;
            mem_addr_q <= mem_addr_d;
        end
    end

endmodule
